// File: rtl/stream_pkt_gen_pkg.sv
// Shared types and constants for the AXI-Stream packet generator and its
// payload word generator.
package stream_pkt_gen_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} pktgen_state_e;

  localparam logic [31:0] LFSR_TAPS        = 32'h8020_0003;
  localparam logic        PKTGEN_MODE_INC  = 1'b0;
  localparam logic        PKTGEN_MODE_LFSR = 1'b1;

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-Stream bundle: data, valid, last forward; ready backward.
interface axi_stream_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/stream_word_gen.sv
// Payload word register: loads the seed on start and steps to the next
// incrementing or LFSR word on each accepted beat.
module stream_word_gen
  import stream_pkt_gen_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              mode,
  input  logic [DATA_W-1:0] seed,
  input  logic              advance,
  output logic [DATA_W-1:0] data
);

  localparam logic [DATA_W-1:0] TAPS = DATA_W'(LFSR_TAPS);
  localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);

  logic mode_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data   <= '0;
      mode_q <= PKTGEN_MODE_INC;
    end else if (load) begin
      mode_q <= mode;
      // An all-zero LFSR state never advances, so it is replaced by 1.
      data   <= (mode == PKTGEN_MODE_LFSR && seed == '0) ? ONE : seed;
    end else if (advance) begin
      if (mode_q == PKTGEN_MODE_LFSR)
        data <= (data >> 1) ^ (data[0] ? TAPS : '0);
      else
        data <= data + ONE;
    end
  end

endmodule

// File: rtl/stream_pkt_gen.sv
// AXI-Stream packet source: emits num_pkts packets of pkt_len beats with a
// programmable idle gap, honouring tready backpressure.
module stream_pkt_gen
  import stream_pkt_gen_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 16,
  parameter int CNT_W      = 16,
  parameter int IFG_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [CNT_W-1:0]  num_pkts,
  input  logic              mode,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pkt_count,
  axi_stream_if.master      m_axis
);

  localparam int                GAP_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  pktgen_state_e     state;
  logic [LEN_W-1:0]  last_idx;
  logic [LEN_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  num_q;
  logic [GAP_W-1:0]  gap_cnt;
  logic              tvalid_q;
  logic              tlast_q;
  logic [DATA_W-1:0] word;
  logic              handshake;
  logic              accept;

  assign handshake = tvalid_q & m_axis.tready;
  assign accept    = start && (state == IDLE);

  assign m_axis.tdata  = word;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;

  stream_word_gen #(.DATA_W(DATA_W)) u_word_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept),
    .mode    (mode),
    .seed    (seed),
    .advance (handshake),
    .data    (word)
  );

  // NOTE: all state here is sequential and uses non-blocking assignments, so
  // every branch below reads the pre-edge values of the other registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      pkt_count <= '0;
      beat_cnt  <= '0;
      gap_cnt   <= '0;
      last_idx  <= '0;
      num_q     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Length 0 behaves as a single-beat packet.
            last_idx  <= (pkt_len == '0) ? '0 : pkt_len - LEN_W'(1);
            num_q     <= num_pkts;
            pkt_count <= '0;
            beat_cnt  <= '0;
            if (num_pkts == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state    <= SEND;
              busy     <= 1'b1;
              tvalid_q <= 1'b1;
              tlast_q  <= (pkt_len <= LEN_W'(1));
            end
          end
        end

        SEND: begin
          if (handshake) begin
            if (tlast_q) begin
              if (pkt_count != CNT_MAX) pkt_count <= pkt_count + CNT_W'(1);
              beat_cnt <= '0;
              if (pkt_count < num_q - CNT_W'(1)) begin
                if (IFG_CYCLES > 0) begin
                  state    <= GAP;
                  tvalid_q <= 1'b0;
                  tlast_q  <= 1'b0;
                  gap_cnt  <= '0;
                end else begin
                  tlast_q <= (last_idx == '0);
                end
              end else begin
                state    <= FIN;
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
              end
            end else begin
              beat_cnt <= beat_cnt + LEN_W'(1);
              tlast_q  <= (beat_cnt + LEN_W'(1) == last_idx);
            end
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state    <= SEND;
            tvalid_q <= 1'b1;
            tlast_q  <= (last_idx == '0);
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        FIN: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
